// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing checker: measures incoming HS/VS, locks onto stable
// timing and regenerates x/y/blank aligned to the incoming sync.
module vga_sync_rx #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_S2A    = 168,
   parameter int V_S2A    = 31,
   parameter int H_MIN    = 700,
   parameter int H_MAX    = 1000,
   parameter int V_MIN    = 500,
   parameter int V_MAX    = 600
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        HS_IN,
   input  logic        VS_IN,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        blank,
   output logic        locked,
   output logic [10:0] h_total,
   output logic [9:0]  v_total,
   output logic        sync_err
);

   localparam logic [10:0] H_FIRST = 11'(H_S2A);
   localparam logic [10:0] H_END   = 11'(H_S2A + H_ACTIVE);
   localparam logic [9:0]  V_FIRST = 10'(V_S2A);
   localparam logic [9:0]  V_END   = 10'(V_S2A + V_ACTIVE);
   localparam logic [10:0] H_LO    = 11'(H_MIN);
   localparam logic [10:0] H_HI    = 11'(H_MAX);
   localparam logic [9:0]  V_LO    = 10'(V_MIN);
   localparam logic [9:0]  V_HI    = 10'(V_MAX);
   localparam logic [10:0] H_SAT   = 11'h7FF;
   localparam logic [9:0]  V_SAT   = 10'h3FF;

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   state_t      state, state_nxt;
   logic        hs_r, hs_d, vs_r, vs_d;
   logic        hs_fall, vs_fall;
   logic [10:0] hcnt, line_len;
   logic [9:0]  vcnt;
   logic        h_valid, timeout, line_done;
   logic [10:0] h_ref, h_ref_nxt;
   logic [9:0]  v_ref, v_ref_nxt;
   logic        h_ref_set, h_ref_set_nxt;
   logic        frame_bad, frame_bad_nxt;
   logic        err_nxt, h_ok, v_ok, blank_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hs_r <= 1'b0;
         hs_d <= 1'b0;
         vs_r <= 1'b0;
         vs_d <= 1'b0;
      end else begin
         hs_r <= HS_IN;
         hs_d <= hs_r;
         vs_r <= VS_IN;
         vs_d <= vs_r;
      end
   end

   assign hs_fall   = hs_d & ~hs_r;
   assign vs_fall   = vs_d & ~vs_r;
   assign timeout   = (hcnt == H_SAT);
   assign line_len  = hcnt + 11'd1;
   // A line is only measured when a previous HS fall anchored hcnt.
   assign line_done = hs_fall & h_valid & ~timeout;

   always_ff @(posedge CLK) begin
      if (RST) begin
         hcnt    <= '0;
         vcnt    <= '0;
         h_valid <= 1'b0;
         h_total <= '0;
         v_total <= '0;
      end else begin
         if (hs_fall)
            hcnt <= '0;
         else if (hcnt != H_SAT)
            hcnt <= hcnt + 11'd1;

         if (timeout)
            h_valid <= 1'b0;
         else if (hs_fall)
            h_valid <= 1'b1;

         if (line_done)
            h_total <= line_len;

         // VS wins over a coincident HS: the new frame starts at line 0.
         if (vs_fall) begin
            v_total <= vcnt;
            vcnt    <= '0;
         end else if (hs_fall && vcnt != V_SAT) begin
            vcnt <= vcnt + 10'd1;
         end
      end
   end

   assign h_ok = h_ref_set & (h_ref >= H_LO) & (h_ref <= H_HI);
   assign v_ok = (vcnt >= V_LO) & (vcnt <= V_HI);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= SEARCH;
         h_ref     <= '0;
         v_ref     <= '0;
         h_ref_set <= 1'b0;
         frame_bad <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         h_ref     <= h_ref_nxt;
         v_ref     <= v_ref_nxt;
         h_ref_set <= h_ref_set_nxt;
         frame_bad <= frame_bad_nxt;
         sync_err  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      h_ref_nxt     = h_ref;
      v_ref_nxt     = v_ref;
      h_ref_set_nxt = h_ref_set;
      frame_bad_nxt = frame_bad;
      err_nxt       = 1'b0;
      case (state)
         SEARCH: begin
            if (vs_fall) begin
               state_nxt     = CHECK;
               frame_bad_nxt = 1'b0;
               h_ref_set_nxt = 1'b0;
            end
         end
         CHECK: begin
            if (line_done) begin
               if (!h_ref_set) begin
                  h_ref_nxt     = line_len;
                  h_ref_set_nxt = 1'b1;
               end else if (line_len != h_ref) begin
                  frame_bad_nxt = 1'b1;
               end
            end
            if (vs_fall) begin
               if (!frame_bad && h_ok && v_ok) begin
                  state_nxt = LOCKED;
                  v_ref_nxt = vcnt;
               end else begin
                  frame_bad_nxt = 1'b0;
                  h_ref_set_nxt = 1'b0;
               end
            end
         end
         LOCKED: begin
            if ((line_done && line_len != h_ref) || (vs_fall && vcnt != v_ref)) begin
               state_nxt = SEARCH;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = SEARCH;
      endcase
      // Lost HS overrides everything; only a drop from LOCKED is reported.
      if (timeout) begin
         state_nxt = SEARCH;
         err_nxt   = (state == LOCKED);
      end
   end

   assign locked = (state == LOCKED);

   // Uses the next state so blank rises on the same edge that lock drops.
   assign blank_nxt = (state_nxt != LOCKED) | (hcnt < H_FIRST) | (hcnt >= H_END) |
                      (vcnt < V_FIRST) | (vcnt >= V_END);

   always_ff @(posedge CLK) begin
      if (RST) begin
         blank <= 1'b1;
         x     <= '0;
         y     <= '0;
      end else begin
         blank <= blank_nxt;
         x     <= blank_nxt ? 10'd0 : 10'(hcnt - H_FIRST);
         y     <= blank_nxt ? 10'd0 : (vcnt - V_FIRST);
      end
   end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx on a scaled-down raster (80x30, HS low px 4..11,
// VS low lines 25..27) so several frames fit in a short run.
module tb_vga_sync_rx;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        HS_IN = 1'b1;
   logic        VS_IN = 1'b1;
   logic [9:0]  x, y, v_total;
   logic [10:0] h_total;
   logic        blank, locked, sync_err;

   vga_sync_rx #(
      .H_ACTIVE(40), .V_ACTIVE(16), .H_S2A(20), .V_S2A(5),
      .H_MIN(60), .H_MAX(100), .V_MIN(20), .V_MAX(40)
   ) dut (
      .CLK(CLK), .RST(RST), .HS_IN(HS_IN), .VS_IN(VS_IN),
      .x(x), .y(y), .blank(blank), .locked(locked),
      .h_total(h_total), .v_total(v_total), .sync_err(sync_err)
   );

   always #5 CLK = ~CLK;

   int checks = 0, errors = 0;
   int gh = 79, gv = 29, hlen = 80, stretch_line = -1;
   bit hs_hold = 1'b0, vs_align = 1'b0;
   int act_cyc, lock_cyc, err_cyc, run, bad_run, mis_xy;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit vs_low(input int v, input int h);
      if (vs_align)
         return (v == 25 && h >= 4) || v == 26 || v == 27 || (v == 28 && h < 4);
      return v >= 25 && v <= 27;
   endfunction

   task automatic clr();
      act_cyc = 0; lock_cyc = 0; err_cyc = 0; run = 0; bad_run = 0; mis_xy = 0;
   endtask

   // One pixel: advance raster, drive, clock, then sample and accumulate.
   // Active pixel (p,L) expects x=p-26, y=0 on line 29 and L+1 on lines 0..14.
   task automatic step();
      int len;
      len = (gv == stretch_line) ? hlen + 1 : hlen;
      gh++;
      if (gh >= len) begin
         gh = 0;
         gv = (gv == 29) ? 0 : gv + 1;
      end
      HS_IN = hs_hold | !(gh >= 4 && gh < 12);
      VS_IN = !vs_low(gv, gh);
      @(posedge CLK);
      #1;
      if (locked) lock_cyc++;
      if (sync_err) err_cyc++;
      if (!blank) begin
         act_cyc++;
         run++;
         if (int'(x) != gh - 26 || int'(y) != ((gv == 29) ? 0 : gv + 1)) mis_xy++;
      end else begin
         if (run != 0 && run != 40) bad_run++;
         run = 0;
      end
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic goto(input int v, input int h);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(gv == v && gh == h) && n < 4000);
      if (n >= 4000) chk("goto_timeout", gv * 1000 + gh, v * 1000 + h);
   endtask

   task automatic wait_lock(input string tag, input int lim);
      int n;
      n = 0;
      while (!locked && n < lim) begin
         step();
         n++;
      end
      chk(tag, int'(locked), 1);
   endtask

   initial begin
      clr();
      // reset state
      RST = 1'b1;
      run_n(3);
      chk("rst_blank", int'(blank), 1);
      chk("rst_locked", int'(locked), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_htot", int'(h_total), 0);
      chk("rst_vtot", int'(v_total), 0);
      chk("rst_err", int'(sync_err), 0);
      RST = 1'b0;

      // acquisition: partial first frame, then a full checked frame
      clr();
      wait_lock("lock_acq", 7200);
      chk("lock_htot", int'(h_total), 80);
      chk("lock_vtot", int'(v_total), 30);
      chk("acq_err", err_cyc, 0);

      // one whole locked frame
      goto(25, 0);
      clr();
      run_n(2400);
      chk("frm_act", act_cyc, 640);
      chk("frm_runs", bad_run, 0);
      chk("frm_xy", mis_xy, 0);
      chk("frm_lock", lock_cyc, 2400);
      chk("frm_err", err_cyc, 0);
      chk("frm_vtot", int'(v_total), 30);

      // active-window edges
      goto(29, 25);
      chk("edge_pre_blank", int'(blank), 1);
      step();
      chk("edge_first_blank", int'(blank), 0);
      chk("edge_first_x", int'(x), 0);
      chk("edge_first_y", int'(y), 0);
      goto(29, 65);
      chk("edge_last_x", int'(x), 39);
      step();
      chk("edge_post_blank", int'(blank), 1);
      chk("edge_post_x", int'(x), 0);
      goto(14, 26);
      chk("edge_last_y", int'(y), 15);
      goto(15, 26);
      chk("edge_below_blank", int'(blank), 1);

      // reset mid-line while locked and active
      goto(0, 40);
      chk("mr_pre_blank", int'(blank), 0);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("mr_blank", int'(blank), 1);
      chk("mr_locked", int'(locked), 0);
      chk("mr_x", int'(x), 0);
      chk("mr_y", int'(y), 0);
      chk("mr_htot", int'(h_total), 0);
      chk("mr_vtot", int'(v_total), 0);
      goto(1, 6);
      chk("mr_first_line", int'(h_total), 0);
      goto(2, 6);
      chk("mr_second_line", int'(h_total), 80);
      wait_lock("mr_relock", 7200);

      // stretch line 5 to 81 clocks
      goto(4, 79);
      stretch_line = 5;
      clr();
      goto(6, 5);
      stretch_line = -1;
      chk("st_err", int'(sync_err), 1);
      chk("st_locked", int'(locked), 0);
      chk("st_blank", int'(blank), 1);
      chk("st_htot", int'(h_total), 81);
      step();
      chk("st_pulse_end", int'(sync_err), 0);
      chk("st_errcnt", err_cyc, 1);
      wait_lock("st_relock", 7200);

      // HS held high for 2100 clocks: hcnt hits 2047 after (21,52)
      goto(26, 6);
      hs_hold = 1'b1;
      clr();
      run_n(2100);
      hs_hold = 1'b0;
      chk("to_errcnt", err_cyc, 1);
      chk("to_lockcyc", lock_cyc, 2046);
      chk("to_locked", int'(locked), 0);
      goto(23, 6);
      chk("to_htot_first", int'(h_total), 80);
      goto(24, 6);
      chk("to_htot_second", int'(h_total), 80);
      wait_lock("to_relock", 7200);

      // VS and HS falling together: no line increment on that edge
      goto(24, 79);
      vs_align = 1'b1;
      goto(25, 6);
      chk("co_vtot", int'(v_total), 30);
      chk("co_locked", int'(locked), 1);
      goto(25, 6);
      chk("co_vtot_next", int'(v_total), 29);
      chk("co_drop", int'(locked), 0);
      vs_align = 1'b0;

      // 40-clock lines: measured but never locked
      goto(29, 79);
      hlen = 40;
      RST = 1'b1;
      step();
      RST = 1'b0;
      clr();
      run_n(3600);
      chk("sh_lock", lock_cyc, 0);
      chk("sh_act", act_cyc, 0);
      chk("sh_err", err_cyc, 0);
      chk("sh_htot", int'(h_total), 40);
      chk("sh_vtot", int'(v_total), 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
